// File: rtl/sparc_lsu_va_rcv_if.sv
// EXU/IFU-to-LSU address bus: E-stage request fields in, M-stage head entry out.
// The master modport is the issuing side; the slave modport is the LSU receiver.
interface sparc_lsu_va_rcv_if;
  logic [47:0] exu_lsu_ldst_va_e;
  logic        alu_ecl_mem_addr_invalid_e_l;
  logic        ifu_lsu_ld_inst_e;
  logic        ifu_lsu_st_inst_e;
  logic [1:0]  ifu_lsu_ldst_size_e;
  logic [1:0]  ifu_lsu_thrid_e;
  logic        lsu_flush_m;
  logic        dcache_rdy;
  logic        lsu_va_vld_m;
  logic [47:0] lsu_va_m;
  logic        lsu_va_st_m;
  logic [1:0]  lsu_va_thrid_m;
  logic [1:0]  lsu_va_size_m;
  logic        lsu_align_excp_m;
  logic        lsu_va_range_excp_m;
  logic        lsu_ifu_ldst_stall;
  logic        lsu_va_ovfl;

  modport master (
    output exu_lsu_ldst_va_e, alu_ecl_mem_addr_invalid_e_l, ifu_lsu_ld_inst_e,
           ifu_lsu_st_inst_e, ifu_lsu_ldst_size_e, ifu_lsu_thrid_e, lsu_flush_m, dcache_rdy,
    input  lsu_va_vld_m, lsu_va_m, lsu_va_st_m, lsu_va_thrid_m, lsu_va_size_m,
           lsu_align_excp_m, lsu_va_range_excp_m, lsu_ifu_ldst_stall, lsu_va_ovfl
  );

  modport slave (
    input  exu_lsu_ldst_va_e, alu_ecl_mem_addr_invalid_e_l, ifu_lsu_ld_inst_e,
           ifu_lsu_st_inst_e, ifu_lsu_ldst_size_e, ifu_lsu_thrid_e, lsu_flush_m, dcache_rdy,
    output lsu_va_vld_m, lsu_va_m, lsu_va_st_m, lsu_va_thrid_m, lsu_va_size_m,
           lsu_align_excp_m, lsu_va_range_excp_m, lsu_ifu_ldst_stall, lsu_va_ovfl
  );
endinterface

// File: rtl/sparc_lsu_va_rcv.sv
// LSU address receiver: captures E-stage ld/st requests with alignment and VA-hole
// checks, buffers them in order and hands the head entry to the D-cache pipe.
module sparc_lsu_va_rcv #(
  parameter int DEPTH = 2,
  parameter int CNTW  = 2
) (
  input logic               rclk,
  input logic               arst,
  sparc_lsu_va_rcv_if.slave va_if
);
  localparam int PTRW = $clog2(DEPTH);

  typedef struct packed {
    logic [47:0] va;
    logic        st;
    logic [1:0]  thrid;
    logic [1:0]  size;
    logic        align;
    logic        range;
  } entry_t;

  entry_t            mem_r [DEPTH];
  logic [CNTW-1:0]   count_r;
  logic [PTRW-1:0]   rd_ptr_r;
  logic [PTRW-1:0]   wr_ptr_r;
  logic              ovfl_r;

  entry_t            head_s;
  entry_t            new_entry_s;
  logic              req_s;
  logic              full_s;
  logic              vld_s;
  logic              excp_s;
  logic              push_s;
  logic              pop_s;

  function automatic logic misaligned(input logic [1:0] size, input logic [2:0] lo);
    logic res;
    case (size)
      2'd0:    res = 1'b0;
      2'd1:    res = lo[0];
      2'd2:    res = |lo[1:0];
      2'd3:    res = |lo;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  function automatic logic [PTRW-1:0] next_ptr(input logic [PTRW-1:0] ptr);
    logic [PTRW-1:0] res;
    if (ptr == PTRW'(DEPTH - 1)) begin
      res = '0;
    end else begin
      res = ptr + PTRW'(1);
    end
    return res;
  endfunction

  // Request decode, full/empty, and push/pop qualification.
  always_comb begin
    head_s            = mem_r[rd_ptr_r];
    req_s             = va_if.ifu_lsu_ld_inst_e | va_if.ifu_lsu_st_inst_e;
    full_s            = (count_r == CNTW'(DEPTH));
    vld_s             = (count_r != CNTW'(0));
    excp_s            = head_s.align | head_s.range;
    // A trapping head entry is handed off in the cycle it shows, ready or not.
    pop_s             = vld_s & (va_if.dcache_rdy | excp_s) & ~va_if.lsu_flush_m;
    push_s            = req_s & ~full_s & ~va_if.lsu_flush_m;
    new_entry_s.va    = va_if.exu_lsu_ldst_va_e;
    new_entry_s.st    = va_if.ifu_lsu_st_inst_e;
    new_entry_s.thrid = va_if.ifu_lsu_thrid_e;
    new_entry_s.size  = va_if.ifu_lsu_ldst_size_e;
    new_entry_s.align = misaligned(va_if.ifu_lsu_ldst_size_e, va_if.exu_lsu_ldst_va_e[2:0]);
    new_entry_s.range = ~va_if.alu_ecl_mem_addr_invalid_e_l;
  end

  // Occupancy, pointers and the sticky overflow flag.
  always_ff @(posedge rclk or posedge arst) begin
    if (arst) begin
      count_r  <= '0;
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      ovfl_r   <= 1'b0;
    end else begin
      if (req_s & full_s) begin
        ovfl_r <= 1'b1;
      end
      if (va_if.lsu_flush_m) begin
        count_r  <= '0;
        rd_ptr_r <= '0;
        wr_ptr_r <= '0;
      end else begin
        if (push_s) begin
          wr_ptr_r <= next_ptr(wr_ptr_r);
        end
        if (pop_s) begin
          rd_ptr_r <= next_ptr(rd_ptr_r);
        end
        case ({push_s, pop_s})
          2'b10:   count_r <= count_r + CNTW'(1);
          2'b01:   count_r <= count_r - CNTW'(1);
          default: count_r <= count_r;
        endcase
      end
    end
  end

  // Entry storage; cleared on reset so the head outputs read zero.
  always_ff @(posedge rclk or posedge arst) begin
    if (arst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (push_s) begin
      mem_r[wr_ptr_r] <= new_entry_s;
    end
  end

  assign va_if.lsu_va_vld_m        = vld_s;
  assign va_if.lsu_va_m            = head_s.va;
  assign va_if.lsu_va_st_m         = head_s.st;
  assign va_if.lsu_va_thrid_m      = head_s.thrid;
  assign va_if.lsu_va_size_m       = head_s.size;
  assign va_if.lsu_align_excp_m    = head_s.align;
  assign va_if.lsu_va_range_excp_m = head_s.range;
  assign va_if.lsu_ifu_ldst_stall  = full_s;
  assign va_if.lsu_va_ovfl         = ovfl_r;
endmodule

// File: tb/tb_sparc_lsu_va_rcv.sv
// Self-checking bench for sparc_lsu_va_rcv: directed scenarios plus randomized
// traffic against a queue-based reference model.
module tb_sparc_lsu_va_rcv;
  localparam int DEPTH = 2;

  typedef struct {
    logic [47:0] va;
    bit          st;
    bit [1:0]    thrid;
    bit [1:0]    size;
    bit          align;
    bit          range;
  } ent_t;

  logic rclk = 1'b0;
  logic arst = 1'b1;
  int   total = 0;
  int   bad = 0;
  ent_t q[$];
  bit   m_ovfl = 1'b0;

  sparc_lsu_va_rcv_if vif ();

  sparc_lsu_va_rcv #(.DEPTH(DEPTH), .CNTW(2)) dut (
    .rclk (rclk),
    .arst (arst),
    .va_if(vif)
  );

  always #5 rclk = ~rclk;

  task automatic idle(input bit rdy);
    vif.exu_lsu_ldst_va_e            = 48'h0;
    vif.alu_ecl_mem_addr_invalid_e_l = 1'b1;
    vif.ifu_lsu_ld_inst_e            = 1'b0;
    vif.ifu_lsu_st_inst_e            = 1'b0;
    vif.ifu_lsu_ldst_size_e          = 2'd0;
    vif.ifu_lsu_thrid_e              = 2'd0;
    vif.lsu_flush_m                  = 1'b0;
    vif.dcache_rdy                   = rdy;
  endtask

  task automatic issue(input bit st, input logic [47:0] va, input bit [1:0] sz, input bit [1:0] thr,
                       input bit hole);
    vif.exu_lsu_ldst_va_e            = va;
    vif.ifu_lsu_ld_inst_e            = ~st;
    vif.ifu_lsu_st_inst_e            = st;
    vif.ifu_lsu_ldst_size_e          = sz;
    vif.ifu_lsu_thrid_e              = thr;
    vif.alu_ecl_mem_addr_invalid_e_l = ~hole;
  endtask

  // Reference model: one clock edge of a bounded in-order queue.
  task automatic tick();
    bit   req, full, pop;
    ent_t e;
    if (arst) begin
      q.delete();
      m_ovfl = 1'b0;
    end else begin
      req  = vif.ifu_lsu_ld_inst_e | vif.ifu_lsu_st_inst_e;
      full = (q.size() == DEPTH);
      pop  = (q.size() != 0) && (vif.dcache_rdy || q[0].align || q[0].range);
      if (req && full) m_ovfl = 1'b1;
      if (vif.lsu_flush_m) begin
        q.delete();
      end else begin
        if (pop) void'(q.pop_front());
        if (req && !full) begin
          e.va    = vif.exu_lsu_ldst_va_e;
          e.st    = vif.ifu_lsu_st_inst_e;
          e.thrid = vif.ifu_lsu_thrid_e;
          e.size  = vif.ifu_lsu_ldst_size_e;
          e.align = (longint'(e.va) % (64'd1 << e.size)) != 0;
          e.range = ~vif.alu_ecl_mem_addr_invalid_e_l;
          q.push_back(e);
        end
      end
    end
    @(posedge rclk);
    @(negedge rclk);
  endtask

  task automatic test_reset();
    idle(1'b0);
    arst = 1'b1;
    tick();
    total++;
    if ({vif.lsu_va_vld_m, vif.lsu_va_m, vif.lsu_va_st_m, vif.lsu_va_thrid_m, vif.lsu_va_size_m,
         vif.lsu_align_excp_m, vif.lsu_va_range_excp_m, vif.lsu_ifu_ldst_stall, vif.lsu_va_ovfl} !== 58'h0) begin
      bad++;
      $display("FAIL reset_outputs: got vld=%b va=%h stall=%b ovfl=%b want all zero",
               vif.lsu_va_vld_m, vif.lsu_va_m, vif.lsu_ifu_ldst_stall, vif.lsu_va_ovfl);
    end
    arst = 1'b0;
    tick();
  endtask

  task automatic test_basic_load();
    idle(1'b1);
    issue(1'b0, 48'h0000_1000_0040, 2'd2, 2'd1, 1'b0);
    tick();
    idle(1'b1);
    total++;
    if ({vif.lsu_va_vld_m, vif.lsu_va_m, vif.lsu_va_st_m, vif.lsu_va_thrid_m, vif.lsu_align_excp_m,
         vif.lsu_va_range_excp_m} !== {1'b1, 48'h0000_1000_0040, 1'b0, 2'd1, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL basic_load: got vld=%b va=%h st=%b thr=%0d al=%b rg=%b want vld=1 va=000010000040 ld thr=1",
               vif.lsu_va_vld_m, vif.lsu_va_m, vif.lsu_va_st_m, vif.lsu_va_thrid_m,
               vif.lsu_align_excp_m, vif.lsu_va_range_excp_m);
    end
    tick();
    total++;
    if (vif.lsu_va_vld_m !== 1'b0) begin
      bad++;
      $display("FAIL basic_load_drain: got vld=%b want 0", vif.lsu_va_vld_m);
    end
  endtask

  task automatic test_misalign();
    idle(1'b0);
    issue(1'b1, 48'h0000_0000_0044, 2'd3, 2'd2, 1'b0);
    tick();
    idle(1'b0);
    total++;
    if ({vif.lsu_va_vld_m, vif.lsu_align_excp_m, vif.lsu_va_st_m, vif.lsu_va_size_m} !== {1'b1, 1'b1, 1'b1, 2'd3}) begin
      bad++;
      $display("FAIL misalign: got vld=%b al=%b st=%b sz=%0d want 1 1 1 3",
               vif.lsu_va_vld_m, vif.lsu_align_excp_m, vif.lsu_va_st_m, vif.lsu_va_size_m);
    end
    tick();
    total++;
    if (vif.lsu_va_vld_m !== 1'b0) begin
      bad++;
      $display("FAIL misalign_pop: got vld=%b want 0 despite rdy=0", vif.lsu_va_vld_m);
    end
  endtask

  task automatic test_va_hole();
    idle(1'b0);
    issue(1'b0, 48'h0000_0000_0080, 2'd2, 2'd3, 1'b1);
    tick();
    idle(1'b0);
    total++;
    if ({vif.lsu_va_vld_m, vif.lsu_va_range_excp_m, vif.lsu_align_excp_m} !== 3'b110) begin
      bad++;
      $display("FAIL va_hole: got vld=%b rg=%b al=%b want 1 1 0",
               vif.lsu_va_vld_m, vif.lsu_va_range_excp_m, vif.lsu_align_excp_m);
    end
    tick();
    total++;
    if (vif.lsu_va_vld_m !== 1'b0) begin
      bad++;
      $display("FAIL va_hole_pop: got vld=%b want 0", vif.lsu_va_vld_m);
    end
  endtask

  task automatic test_full_overflow();
    idle(1'b0);
    issue(1'b0, 48'h100, 2'd3, 2'd0, 1'b0);
    tick();
    issue(1'b0, 48'h108, 2'd3, 2'd0, 1'b0);
    tick();
    total++;
    if ({vif.lsu_ifu_ldst_stall, vif.lsu_va_ovfl} !== 2'b10) begin
      bad++;
      $display("FAIL full_stall: got stall=%b ovfl=%b want 1 0", vif.lsu_ifu_ldst_stall, vif.lsu_va_ovfl);
    end
    issue(1'b0, 48'h110, 2'd3, 2'd0, 1'b0);
    tick();
    total++;
    if ({vif.lsu_ifu_ldst_stall, vif.lsu_va_ovfl} !== 2'b11) begin
      bad++;
      $display("FAIL overflow: got stall=%b ovfl=%b want 1 1", vif.lsu_ifu_ldst_stall, vif.lsu_va_ovfl);
    end
    idle(1'b1);
    total++;
    if ({vif.lsu_va_vld_m, vif.lsu_va_m} !== {1'b1, 48'h100}) begin
      bad++;
      $display("FAIL drain_first: got vld=%b va=%h want 1 100", vif.lsu_va_vld_m, vif.lsu_va_m);
    end
    tick();
    total++;
    if ({vif.lsu_va_vld_m, vif.lsu_va_m, vif.lsu_ifu_ldst_stall} !== {1'b1, 48'h108, 1'b0}) begin
      bad++;
      $display("FAIL drain_second: got vld=%b va=%h stall=%b want 1 108 0",
               vif.lsu_va_vld_m, vif.lsu_va_m, vif.lsu_ifu_ldst_stall);
    end
    tick();
    total++;
    if ({vif.lsu_va_vld_m, vif.lsu_va_ovfl} !== 2'b01) begin
      bad++;
      $display("FAIL drain_empty: got vld=%b ovfl=%b want 0 1 (dropped entry, sticky ovfl)",
               vif.lsu_va_vld_m, vif.lsu_va_ovfl);
    end
  endtask

  task automatic test_back_to_back();
    logic [47:0] prev;
    idle(1'b1);
    issue(1'b0, 48'h200, 2'd0, 2'd0, 1'b0);
    tick();
    prev = 48'h200;
    for (int i = 1; i <= 6; i++) begin
      issue(1'b0, 48'h200 + 48'(i * 8), 2'd0, 2'(i), 1'b0);
      total++;
      if ({vif.lsu_va_vld_m, vif.lsu_va_m, vif.lsu_ifu_ldst_stall} !== {1'b1, prev, 1'b0}) begin
        bad++;
        $display("FAIL back_to_back[%0d]: got vld=%b va=%h stall=%b want 1 %h 0",
                 i, vif.lsu_va_vld_m, vif.lsu_va_m, vif.lsu_ifu_ldst_stall, prev);
      end
      tick();
      prev = 48'h200 + 48'(i * 8);
    end
    idle(1'b1);
    tick();
    tick();
  endtask

  task automatic test_flush();
    idle(1'b0);
    issue(1'b0, 48'h300, 2'd0, 2'd0, 1'b0);
    tick();
    issue(1'b1, 48'h308, 2'd0, 2'd0, 1'b0);
    tick();
    issue(1'b0, 48'h310, 2'd0, 2'd0, 1'b0);
    vif.lsu_flush_m = 1'b1;
    tick();
    idle(1'b0);
    total++;
    if ({vif.lsu_va_vld_m, vif.lsu_ifu_ldst_stall} !== 2'b00) begin
      bad++;
      $display("FAIL flush: got vld=%b stall=%b want 0 0", vif.lsu_va_vld_m, vif.lsu_ifu_ldst_stall);
    end
    tick();
    total++;
    if (vif.lsu_va_vld_m !== 1'b0) begin
      bad++;
      $display("FAIL flush_no_new: got vld=%b want 0", vif.lsu_va_vld_m);
    end
  endtask

  task automatic test_random();
    logic [47:0] va;
    ent_t        h;
    for (int n = 0; n < 400; n++) begin
      idle(1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) != 0) begin
        va = {$urandom, $urandom};
        if ($urandom_range(0, 1) != 0) va[2:0] = 3'b000;
        issue(1'($urandom_range(0, 1)), va, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
              $urandom_range(0, 9) == 0);
        if ($urandom_range(0, 7) == 0) vif.ifu_lsu_ld_inst_e = 1'b1;
      end
      vif.lsu_flush_m = ($urandom_range(0, 24) == 0);
      tick();
      total++;
      if ({vif.lsu_va_vld_m, vif.lsu_ifu_ldst_stall, vif.lsu_va_ovfl} !==
          {q.size() != 0, q.size() == DEPTH, m_ovfl}) begin
        bad++;
        $display("FAIL random_ctl[%0d]: got vld=%b stall=%b ovfl=%b want %b %b %b", n,
                 vif.lsu_va_vld_m, vif.lsu_ifu_ldst_stall, vif.lsu_va_ovfl,
                 q.size() != 0, q.size() == DEPTH, m_ovfl);
      end
      if (q.size() != 0) begin
        h = q[0];
        total++;
        if ({vif.lsu_va_m, vif.lsu_va_st_m, vif.lsu_va_thrid_m, vif.lsu_va_size_m, vif.lsu_align_excp_m,
             vif.lsu_va_range_excp_m} !== {h.va, h.st, h.thrid, h.size, h.align, h.range}) begin
          bad++;
          $display("FAIL random_head[%0d]: got va=%h st=%b thr=%0d sz=%0d al=%b rg=%b want %h %b %0d %0d %b %b",
                   n, vif.lsu_va_m, vif.lsu_va_st_m, vif.lsu_va_thrid_m, vif.lsu_va_size_m,
                   vif.lsu_align_excp_m, vif.lsu_va_range_excp_m,
                   h.va, h.st, h.thrid, h.size, h.align, h.range);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    idle(1'b0);
    issue(1'b0, 48'h400, 2'd0, 2'd1, 1'b0);
    tick();
    issue(1'b0, 48'h408, 2'd0, 2'd1, 1'b0);
    tick();
    issue(1'b0, 48'h410, 2'd0, 2'd1, 1'b0);
    tick();
    idle(1'b0);
    @(posedge rclk);
    #2;
    arst = 1'b1;
    #1;
    total++;
    if ({vif.lsu_va_vld_m, vif.lsu_va_m, vif.lsu_va_st_m, vif.lsu_va_thrid_m, vif.lsu_va_size_m,
         vif.lsu_align_excp_m, vif.lsu_va_range_excp_m, vif.lsu_ifu_ldst_stall, vif.lsu_va_ovfl} !== 58'h0) begin
      bad++;
      $display("FAIL async_reset: got vld=%b va=%h thr=%0d stall=%b ovfl=%b want all zero",
               vif.lsu_va_vld_m, vif.lsu_va_m, vif.lsu_va_thrid_m, vif.lsu_ifu_ldst_stall, vif.lsu_va_ovfl);
    end
    @(negedge rclk);
    tick();
    arst = 1'b0;
    tick();
    total++;
    if ({vif.lsu_va_vld_m, vif.lsu_ifu_ldst_stall} !== 2'b00) begin
      bad++;
      $display("FAIL async_reset_after: got vld=%b stall=%b want 0 0", vif.lsu_va_vld_m, vif.lsu_ifu_ldst_stall);
    end
  endtask

  initial begin
    idle(1'b0);
    @(negedge rclk);
    test_reset();
    test_basic_load();
    test_misalign();
    test_va_hole();
    test_full_overflow();
    test_back_to_back();
    test_flush();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
